// File: rtl/stream_framer.sv
// Packs a valid/ready word stream into frames of one header word plus PAYLOAD_WORDS payload words.
// The output is a single registered slot that is reloaded only when it is empty or being drained.
module stream_framer #(
  parameter int          DATA_WIDTH    = 64,
  parameter int          PAYLOAD_WORDS = 8,
  parameter logic [15:0] HEADER_MAGIC  = 16'hA5C3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  dout_last,
  input  logic                  dout_ready,
  output logic [31:0]           frame_count
);

  localparam logic [15:0] PW16     = 16'(PAYLOAD_WORDS);
  localparam logic [15:0] LAST_IDX = 16'(PAYLOAD_WORDS - 1);

  typedef enum logic [0:0] {IDLE, PAYLOAD} state_t;

  state_t                state, state_nx;
  logic [31:0]           seq, seq_nx;
  logic [15:0]           word_cnt, word_cnt_nx;
  logic [DATA_WIDTH-1:0] dout_nx;
  logic                  dout_valid_nx, dout_last_nx;
  logic                  slot_free, accept;

  // Header occupies the low 64 bits; any extra MSBs stay zero.
  function automatic logic [DATA_WIDTH-1:0] make_header(input logic [31:0] s);
    logic [DATA_WIDTH-1:0] h;
    h        = '0;
    h[63:0]  = {HEADER_MAGIC, PW16, s};
    return h;
  endfunction

  assign slot_free = !dout_valid || dout_ready;
  assign din_ready = (state == PAYLOAD) && slot_free;
  assign accept    = din_valid && din_ready;

  always_comb begin
    state_nx      = state;
    seq_nx        = seq;
    word_cnt_nx   = word_cnt;
    dout_nx       = dout;
    dout_valid_nx = dout_valid;
    dout_last_nx  = dout_last;
    unique case (state)
      IDLE: begin
        if (enable && din_valid && slot_free) begin
          dout_nx       = make_header(seq);
          dout_valid_nx = 1'b1;
          dout_last_nx  = 1'b0;
          seq_nx        = seq + 32'd1;
          word_cnt_nx   = '0;
          state_nx      = PAYLOAD;
        end else if (slot_free) begin
          dout_valid_nx = 1'b0;
          dout_last_nx  = 1'b0;
        end
      end
      PAYLOAD: begin
        if (accept) begin
          dout_nx       = din;
          dout_valid_nx = 1'b1;
          word_cnt_nx   = word_cnt + 16'd1;
          dout_last_nx  = (word_cnt == LAST_IDX);
          if (word_cnt == LAST_IDX) state_nx = IDLE;
        end else if (slot_free) begin
          // Bubble: slot drained with nothing new to load.
          dout_valid_nx = 1'b0;
          dout_last_nx  = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      seq        <= '0;
      word_cnt   <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
    end else begin
      state      <= state_nx;
      seq        <= seq_nx;
      word_cnt   <= word_cnt_nx;
      dout       <= dout_nx;
      dout_valid <= dout_valid_nx;
      dout_last  <= dout_last_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  frame_count <= '0;
    else if (dout_valid && dout_ready && dout_last) frame_count <= frame_count + 32'd1;
  end

endmodule

// File: tb/tb_stream_framer.sv
// Directed bench for stream_framer: a PAYLOAD_WORDS=4 instance and a PAYLOAD_WORDS=1 instance
// share inputs; sel picks which one the stimulus loop follows and compares.
module tb_stream_framer;

  logic        clk = 1'b0;
  logic        rst, enable, din_valid, dout_ready;
  logic [63:0] din;

  logic [63:0] dout0, dout1;
  logic        dout_valid0, dout_valid1, dout_last0, dout_last1, din_ready0, din_ready1;
  logic [31:0] frame_count0, frame_count1;

  logic        sel = 1'b0;
  logic [63:0] cur_dout;
  logic        cur_valid, cur_last, cur_din_ready;
  logic [31:0] cur_fc;

  assign cur_dout      = sel ? dout1 : dout0;
  assign cur_valid     = sel ? dout_valid1 : dout_valid0;
  assign cur_last      = sel ? dout_last1 : dout_last0;
  assign cur_din_ready = sel ? din_ready1 : din_ready0;
  assign cur_fc        = sel ? frame_count1 : frame_count0;

  stream_framer #(.DATA_WIDTH(64), .PAYLOAD_WORDS(4), .HEADER_MAGIC(16'hA5C3)) dut (
    .clk(clk), .rst(rst), .enable(enable), .din(din), .din_valid(din_valid),
    .din_ready(din_ready0), .dout(dout0), .dout_valid(dout_valid0), .dout_last(dout_last0),
    .dout_ready(dout_ready), .frame_count(frame_count0));

  stream_framer #(.DATA_WIDTH(64), .PAYLOAD_WORDS(1), .HEADER_MAGIC(16'hA5C3)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .din(din), .din_valid(din_valid),
    .din_ready(din_ready1), .dout(dout1), .dout_valid(dout_valid1), .dout_last(dout_last1),
    .dout_ready(dout_ready), .frame_count(frame_count1));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [63:0] got_d[$];
  logic        got_l[$];
  int          got_cyc[$];
  int          stall_viol, bubbles, en_cyc;

  int          rdy_pat [6] = '{1, 0, 0, 1, 0, 1};
  logic [63:0] exp4_d [10] = '{64'hA5C3_0004_0000_0000, 64'd1, 64'd2, 64'd3, 64'd4,
                               64'hA5C3_0004_0000_0001, 64'd5, 64'd6, 64'd7, 64'd8};
  logic        exp4_l [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [63:0] exp1_d [6]  = '{64'hA5C3_0001_0000_0000, 64'd1, 64'hA5C3_0001_0000_0001, 64'd2,
                               64'hA5C3_0001_0000_0002, 64'd3};
  logic        exp1_l [6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    din_valid  = 1'b0;
    enable     = 1'b0;
    dout_ready = 1'b1;
    din        = '0;
    rst        = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Feeds words 1..n_in and records every transferred output beat; starts and ends at posedge+1.
  task automatic run(input int n_in, input bit rdy_mode, input bit vld_mode, input bit en_drop,
                     input int n_beats);
    int          in_idx = 0;
    int          cyc    = 0;
    int          hold   = 0;
    bit          acc;
    bit          prev_stall = 1'b0;
    logic [63:0] prev_d = '0;
    got_d.delete(); got_l.delete(); got_cyc.delete();
    stall_viol = 0; bubbles = 0; en_cyc = -1;
    enable = 1'b1;
    while (got_d.size() < n_beats && cyc < 400) begin
      dout_ready = rdy_mode ? (rdy_pat[cyc % 6] != 0) : 1'b1;
      din_valid  = (in_idx < n_in) && (vld_mode ? (cyc % 2 == 0) : 1'b1);
      din        = 64'(in_idx + 1);
      if (en_drop) begin
        if (in_idx >= 2 && hold < 6) enable = 1'b0;
        else begin
          if (!enable && en_cyc < 0) en_cyc = cyc;
          enable = 1'b1;
        end
        if (in_idx >= 4 && hold < 6) hold++;
      end
      #4;
      if (cur_valid && dout_ready) begin
        got_d.push_back(cur_dout);
        got_l.push_back(cur_last);
        got_cyc.push_back(cyc);
      end
      if (prev_stall && cur_dout != prev_d) stall_viol++;
      if (cur_valid && !dout_ready && cur_din_ready) stall_viol++;
      if (!cur_valid) bubbles++;
      prev_stall = cur_valid && !dout_ready;
      prev_d     = cur_dout;
      acc        = din_valid && cur_din_ready;
      @(posedge clk);
      #1;
      if (acc) in_idx++;
      cyc++;
    end
  endtask

  task automatic compare_beats(input string tag, input int n, input bit pw1);
    check({tag, "_count"}, 64'(got_d.size()), 64'(n));
    for (int i = 0; i < n && i < got_d.size(); i++) begin
      if (pw1) begin
        check($sformatf("%s_d%0d", tag, i), got_d[i], exp1_d[i]);
        check($sformatf("%s_l%0d", tag, i), 64'(got_l[i]), 64'(exp1_l[i]));
      end else begin
        check($sformatf("%s_d%0d", tag, i), got_d[i], exp4_d[i]);
        check($sformatf("%s_l%0d", tag, i), 64'(got_l[i]), 64'(exp4_l[i]));
      end
    end
  endtask

  initial begin
    // Reset held with a word pending
    rst = 1'b0; enable = 1'b1; din_valid = 1'b1; dout_ready = 1'b1; din = 64'd5;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", cur_dout, 64'd0);
    check("rst_valid", 64'(cur_valid), 64'd0);
    check("rst_last", 64'(cur_last), 64'd0);
    check("rst_din_ready", 64'(cur_din_ready), 64'd0);
    check("rst_frame_count", 64'(cur_fc), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("first_hdr", cur_dout, 64'hA5C3_0004_0000_0000);
    check("first_hdr_valid", 64'(cur_valid), 64'd1);
    check("first_hdr_last", 64'(cur_last), 64'd0);

    // Full rate
    do_reset();
    run(8, 1'b0, 1'b0, 1'b0, 10);
    compare_beats("full", 10, 1'b0);
    if (got_cyc.size() == 10) check("full_span", 64'(got_cyc[9] - got_cyc[0]), 64'd9);
    check("full_frames", 64'(cur_fc), 64'd2);

    // Backpressure
    do_reset();
    run(8, 1'b1, 1'b0, 1'b0, 10);
    compare_beats("bp", 10, 1'b0);
    check("bp_stable", 64'(stall_viol), 64'd0);
    check("bp_frames", 64'(cur_fc), 64'd2);

    // Enable dropped after the second payload word
    do_reset();
    run(8, 1'b0, 1'b0, 1'b1, 10);
    compare_beats("en", 10, 1'b0);
    if (got_cyc.size() == 10) check("en_hdr_wait", 64'(got_cyc[5]), 64'(en_cyc + 1));
    check("en_frames", 64'(cur_fc), 64'd2);

    // Gapped input
    do_reset();
    run(8, 1'b0, 1'b1, 1'b0, 10);
    compare_beats("gap", 10, 1'b0);
    check("gap_bubbles", 64'(bubbles > 0), 64'd1);

    // Reset mid-frame, after payload word 2
    do_reset();
    run(8, 1'b0, 1'b0, 1'b0, 3);
    check("mid_pre_count", 64'(got_d.size()), 64'd3);
    rst = 1'b0;
    #1;
    check("mid_dout", cur_dout, 64'd0);
    check("mid_valid", 64'(cur_valid), 64'd0);
    check("mid_last", 64'(cur_last), 64'd0);
    check("mid_din_ready", 64'(cur_din_ready), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    check("mid_frame_count", 64'(cur_fc), 64'd0);
    run(8, 1'b0, 1'b0, 1'b0, 10);
    compare_beats("mid_after", 10, 1'b0);

    // Single-word frames
    sel = 1'b1;
    do_reset();
    run(3, 1'b0, 1'b0, 1'b0, 6);
    compare_beats("pw1", 6, 1'b1);
    if (got_cyc.size() == 6) check("pw1_span", 64'(got_cyc[5] - got_cyc[0]), 64'd5);
    check("pw1_frames", 64'(cur_fc), 64'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
